// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace producer.
// TRACE_CYCLE_EN adds a 32-bit cycle stamp member to trace_rec_t.
package trace_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
`ifdef TRACE_CYCLE_EN
        logic [31:0]          cycle;
`endif
        logic [XLEN-1:0]      pc;
        logic [31:0]          inst;
        logic                 rdv;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rd_data;
        logic                 pcv;
        logic [XLEN-1:0]      pc_x;
    } trace_rec_t;
endpackage

// File: rtl/trace_gen_if.sv
// Valid/ready retire record stream between trace_gen and the trace sink.
interface trace_gen_if;
    import trace_pkg::*;

    logic       rec_valid;
    logic       rec_ready;
    trace_rec_t rec;

    modport master (output rec_valid, output rec, input rec_ready);
    modport slave  (input rec_valid, input rec, output rec_ready);
endinterface

// File: rtl/trace_fifo.sv
// DEPTH-entry FIFO of trace records; head is read straight from storage
// registers, so a write into an empty FIFO becomes visible one cycle later.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  trace_rec_t             din,
    output trace_rec_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // A pop frees the slot in the same cycle, so push-while-full is legal with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/trace_gen.sv
// Retire trace producer: stages issued instructions, merges next-cycle execution
// results and queues one record per instruction. TRACE_CYCLE_EN adds a cycle stamp.
module trace_gen
    import trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = trace_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_v_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          inst_i,
    input  logic                 rd_v,
    input  logic [REG_IDX_W-1:0] rd_x,
    input  logic [XLEN-1:0]      rd_data,
    input  logic                 pcv,
    input  logic [XLEN-1:0]      pc_x,
    output logic                 stall_o,
    trace_gen_if.master          rec_if,
    output logic [31:0]          retired,
    output logic                 overflow
);
    logic                   stg_v;
    logic [XLEN-1:0]        stg_pc;
    logic [31:0]            stg_inst;
    trace_rec_t             rec_new;
    trace_rec_t             head;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic [$clog2(DEPTH):0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v    <= 1'b0;
            stg_pc   <= '0;
            stg_inst <= '0;
        end else begin
            stg_v <= inst_v_i;
            if (inst_v_i) begin
                stg_pc   <= pc_i;
                stg_inst <= inst_i;
            end
        end
    end

`ifdef TRACE_CYCLE_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        rec_new         = '0;
        rec_new.pc      = stg_pc;
        rec_new.inst    = stg_inst;
        rec_new.rdv     = rd_v;
        rec_new.rd      = rd_v ? rd_x : '0;
        rec_new.rd_data = rd_v ? rd_data : '0;
        rec_new.pcv     = pcv;
        rec_new.pc_x    = pcv ? pc_x : '0;
`ifdef TRACE_CYCLE_EN
        rec_new.cycle   = cycle_cnt;
`endif
    end

    assign pop = rec_if.rec_valid && rec_if.rec_ready;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stg_v),
        .pop   (pop),
        .din   (rec_new),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign rec_if.rec_valid = !empty;
    assign rec_if.rec       = head;

    // Threshold leaves room for one more staged instruction behind a full FIFO.
    assign stall_o = (int'(count) + int'(stg_v)) >= (DEPTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired  <= '0;
            overflow <= 1'b0;
        end else if (stg_v) begin
            retired <= retired + 32'd1;
            if (full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
